// File: rtl/sar_pkg.sv
// ============================================================================
// Module      : sar_pkg
// Description : Shared types and default sizing for the SAR controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sar_pkg;

    localparam int SAR_NBITS_DEF    = 8;
    localparam int SAR_SAMP_CYC_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_COMP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } sar_state_t;

endpackage : sar_pkg

`default_nettype wire

// File: rtl/sar_if.sv
// ============================================================================
// Module      : sar_if
// Description : Control, comparator and result signals of the SAR controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sar_if
    import sar_pkg::*;
#(
    parameter int NBITS = SAR_NBITS_DEF
);
    logic             start;
    logic             comp_p;
    logic             comp_n;
    logic             samp;
    logic             comp_clk;
    logic [NBITS-1:0] dac_p;
    logic [NBITS-1:0] dac_n;
    logic [NBITS-1:0] data;
    logic             valid;
    logic             busy;
    logic             err;

    modport slave (
        input  start, comp_p, comp_n,
        output samp, comp_clk, dac_p, dac_n, data, valid, busy, err
    );

    modport master (
        output start, comp_p, comp_n,
        input  samp, comp_clk, dac_p, dac_n, data, valid, busy, err
    );

endinterface : sar_if

`default_nettype wire

// File: rtl/sar_ctrl.sv
// ============================================================================
// Module      : sar_ctrl
// Description : Successive-approximation ADC sequencer with registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_ctrl
    import sar_pkg::*;
#(
    parameter int NBITS    = SAR_NBITS_DEF,
    parameter int SAMP_CYC = SAR_SAMP_CYC_DEF
) (
    input  wire logic clk,
    input  wire logic rst_n,
    sar_if.slave      bus
);

    localparam int               IDX_W     = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(NBITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [3:0]       SAMP_LAST = 4'(SAMP_CYC - 1);
    localparam logic [NBITS-1:0] CODE_MSB  = {1'b1, {(NBITS-1){1'b0}}};

    sar_state_t       state_q;
    logic [3:0]       cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [NBITS-1:0] code_q;
    logic [NBITS-1:0] data_q;
    logic             samp_q;
    logic             comp_clk_q;
    logic             valid_q;
    logic             busy_q;
    logic             err_q;

    logic             w_keep;
    logic             w_undecided;
    logic             w_accept;
    logic [IDX_W-1:0] w_idx_dn;

    // A tie on the comparator is treated as "below" so the bit is cleared.
    assign w_keep      = bus.comp_p & ~bus.comp_n;
    assign w_undecided = (bus.comp_p == bus.comp_n);
    assign w_accept    = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_idx_dn    = idx_q - IDX_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= IDX_MSB;
            code_q     <= '0;
            data_q     <= '0;
            samp_q     <= 1'b0;
            comp_clk_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end

                ST_SAMPLE: begin
                    if (cnt_q == SAMP_LAST) begin
                        state_q    <= ST_COMP;
                        cnt_q      <= '0;
                        code_q     <= CODE_MSB;
                        samp_q     <= 1'b0;
                        comp_clk_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end

                ST_COMP: begin
                    code_q[idx_q] <= w_keep;
                    if (idx_q != '0) begin
                        code_q[w_idx_dn] <= 1'b1;
                    end
                    if (w_undecided) begin
                        err_q <= 1'b1;
                    end
                    comp_clk_q <= 1'b0;
                    state_q    <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (idx_q == '0) begin
                        state_q <= ST_DONE;
                        data_q  <= code_q;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q      <= w_idx_dn;
                        comp_clk_q <= 1'b1;
                        state_q    <= ST_COMP;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q    <= ST_IDLE;
                    samp_q     <= 1'b0;
                    comp_clk_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase

            // Accepting a request overrides the IDLE/DONE defaults above.
            if (w_accept) begin
                state_q    <= ST_SAMPLE;
                cnt_q      <= '0;
                idx_q      <= IDX_MSB;
                code_q     <= '0;
                err_q      <= 1'b0;
                samp_q     <= 1'b1;
                comp_clk_q <= 1'b0;
                busy_q     <= 1'b1;
            end
        end
    end

    assign bus.samp     = samp_q;
    assign bus.comp_clk = comp_clk_q;
    assign bus.dac_p    = code_q;
    assign bus.dac_n    = ~code_q;
    assign bus.data     = data_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;

endmodule : sar_ctrl

`default_nettype wire

// File: tb/tb_sar_ctrl.sv
// ============================================================================
// Module      : tb_sar_ctrl
// Description : Directed self-checking bench for sar_ctrl (NBITS=8, SAMP_CYC=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sar_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sar_if #(.NBITS(8)) bus();

    sar_ctrl #(.NBITS(8), .SAMP_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] vin         = 8'h00;
    logic       force_undec = 1'b0;
    int         pcnt        = 0;
    int         vectors     = 0;
    int         miscompares = 0;

    // Ideal comparator: input at or above the DAC code keeps the trial bit.
    always_comb begin
        bus.comp_p = (vin >= bus.dac_p);
        bus.comp_n = !(vin >= bus.dac_p);
        if (force_undec && pcnt == 4) begin
            bus.comp_p = 1'b1;
            bus.comp_n = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (bus.samp)          pcnt <= 0;
        else if (bus.comp_clk) pcnt <= pcnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic kick(input logic hold);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
    endtask

    // Steps from conversion cycle 0 until valid, checking per-cycle invariants.
    task automatic run_conv(output int lat, output int nsamp, output int ncomp,
                            output logic [7:0] dac_c2, output logic [7:0] data_pre);
        lat = -1; nsamp = 0; ncomp = 0; dac_c2 = 8'h00; data_pre = bus.data;
        for (int c = 0; c < 40; c++) begin
            vectors += 3;
            if (bus.dac_n !== ~bus.dac_p) begin
                miscompares++;
                $display("FAIL inv_dac c=%0d dac_n=%h required %h", c, bus.dac_n, ~bus.dac_p);
            end
            if (bus.samp && bus.comp_clk) begin
                miscompares++;
                $display("FAIL inv_overlap c=%0d samp=1 comp_clk=1 required not both", c);
            end
            if (bus.busy !== !bus.valid) begin
                miscompares++;
                $display("FAIL inv_busy c=%0d busy=%b required %b", c, bus.busy, !bus.valid);
            end
            if (bus.samp)     nsamp++;
            if (bus.comp_clk) ncomp++;
            if (c == 2)       dac_c2 = bus.dac_p;
            if (bus.valid === 1'b1) begin
                lat = c;
                break;
            end
            data_pre = bus.data;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors += 8;
        if (bus.samp !== 1'b0)       begin miscompares++; $display("FAIL rst_samp got %b want 0", bus.samp); end
        if (bus.comp_clk !== 1'b0)   begin miscompares++; $display("FAIL rst_comp_clk got %b want 0", bus.comp_clk); end
        if (bus.dac_p !== 8'h00)     begin miscompares++; $display("FAIL rst_dac_p got %h want 00", bus.dac_p); end
        if (bus.dac_n !== 8'hFF)     begin miscompares++; $display("FAIL rst_dac_n got %h want ff", bus.dac_n); end
        if (bus.data !== 8'h00)      begin miscompares++; $display("FAIL rst_data got %h want 00", bus.data); end
        if (bus.valid !== 1'b0)      begin miscompares++; $display("FAIL rst_valid got %b want 0", bus.valid); end
        if (bus.busy !== 1'b0)       begin miscompares++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        if (bus.err !== 1'b0)        begin miscompares++; $display("FAIL rst_err got %b want 0", bus.err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, ns, nc;
        logic [7:0] d2, dp;
        vin = 8'hA5;
        kick(1'b0);
        vectors += 2;
        if (bus.samp !== 1'b1)   begin miscompares++; $display("FAIL basic_samp0 got %b want 1", bus.samp); end
        if (bus.dac_p !== 8'h00) begin miscompares++; $display("FAIL basic_dac0 got %h want 00", bus.dac_p); end
        run_conv(lat, ns, nc, d2, dp);
        vectors += 7;
        if (lat != 18)          begin miscompares++; $display("FAIL basic_latency got %0d want 18", lat); end
        if (ns != 2)            begin miscompares++; $display("FAIL basic_samp_cycles got %0d want 2", ns); end
        if (nc != 8)            begin miscompares++; $display("FAIL basic_comp_pulses got %0d want 8", nc); end
        if (d2 !== 8'h80)       begin miscompares++; $display("FAIL basic_first_trial got %h want 80", d2); end
        if (dp !== 8'h00)       begin miscompares++; $display("FAIL basic_data_held got %h want 00", dp); end
        if (bus.data !== 8'hA5) begin miscompares++; $display("FAIL basic_data got %h want a5", bus.data); end
        if (bus.err !== 1'b0)   begin miscompares++; $display("FAIL basic_err got %b want 0", bus.err); end
        @(posedge clk);
        #1;
        vectors += 2;
        if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL basic_strobe got %b want 0", bus.valid); end
        if (bus.busy !== 1'b0)  begin miscompares++; $display("FAIL basic_idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_err();
        int lat, ns, nc;
        logic [7:0] d2, dp;
        vin = 8'hFF;
        force_undec = 1'b1;
        kick(1'b0);
        run_conv(lat, ns, nc, d2, dp);
        force_undec = 1'b0;
        vectors += 4;
        if (lat != 18)          begin miscompares++; $display("FAIL err_latency got %0d want 18", lat); end
        if (dp !== 8'hA5)       begin miscompares++; $display("FAIL err_data_held got %h want a5", dp); end
        if (bus.data !== 8'hF7) begin miscompares++; $display("FAIL err_data got %h want f7", bus.data); end
        if (bus.err !== 1'b1)   begin miscompares++; $display("FAIL err_flag_done got %b want 1", bus.err); end
        repeat (3) @(posedge clk);
        #1;
        vectors += 2;
        if (bus.err !== 1'b1)   begin miscompares++; $display("FAIL err_sticky_idle got %b want 1", bus.err); end
        if (bus.data !== 8'hF7) begin miscompares++; $display("FAIL err_data_idle got %h want f7", bus.data); end
        vin = 8'h11;
        kick(1'b0);
        vectors += 1;
        if (bus.err !== 1'b0)   begin miscompares++; $display("FAIL err_clear_on_start got %b want 0", bus.err); end
        run_conv(lat, ns, nc, d2, dp);
        vectors += 2;
        if (bus.data !== 8'h11) begin miscompares++; $display("FAIL err_next_data got %h want 11", bus.data); end
        if (bus.err !== 1'b0)   begin miscompares++; $display("FAIL err_next_flag got %b want 0", bus.err); end
    endtask

    task automatic test_back_to_back();
        int lat, ns, nc;
        logic [7:0] d2, dp;
        vin = 8'h00;
        kick(1'b1);
        run_conv(lat, ns, nc, d2, dp);
        vectors += 2;
        if (lat != 18)          begin miscompares++; $display("FAIL b2b_lat1 got %0d want 18", lat); end
        if (bus.data !== 8'h00) begin miscompares++; $display("FAIL b2b_data1 got %h want 00", bus.data); end
        vin = 8'hFF;
        @(posedge clk);
        #1;
        vectors += 2;
        if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL b2b_strobe got %b want 0", bus.valid); end
        if (bus.samp !== 1'b1)  begin miscompares++; $display("FAIL b2b_resample got %b want 1", bus.samp); end
        run_conv(lat, ns, nc, d2, dp);
        bus.start = 1'b0;
        vectors += 3;
        if (lat != 18)          begin miscompares++; $display("FAIL b2b_lat2 got %0d want 18", lat); end
        if (dp !== 8'h00)       begin miscompares++; $display("FAIL b2b_data_held got %h want 00", dp); end
        if (bus.data !== 8'hFF) begin miscompares++; $display("FAIL b2b_data2 got %h want ff", bus.data); end
        @(posedge clk);
        #1;
        vectors += 1;
        if (bus.busy !== 1'b0)  begin miscompares++; $display("FAIL b2b_idle got %b want 0", bus.busy); end
    endtask

    task automatic test_ignore_start();
        int nvalid = 0;
        int vcyc = -1;
        vin = 8'h3C;
        kick(1'b0);
        for (int c = 0; c < 45; c++) begin
            if (c == 5) bus.start = 1'b1;
            if (c == 6) bus.start = 1'b0;
            if (bus.valid === 1'b1) begin
                nvalid++;
                vcyc = c;
            end
            @(posedge clk);
            #1;
        end
        vectors += 4;
        if (nvalid != 1)        begin miscompares++; $display("FAIL ign_valid_count got %0d want 1", nvalid); end
        if (vcyc != 18)         begin miscompares++; $display("FAIL ign_valid_cycle got %0d want 18", vcyc); end
        if (bus.data !== 8'h3C) begin miscompares++; $display("FAIL ign_data got %h want 3c", bus.data); end
        if (bus.busy !== 1'b0)  begin miscompares++; $display("FAIL ign_idle got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_abort();
        int lat, ns, nc;
        int nvalid = 0;
        logic [7:0] d2, dp;
        vin = 8'h5A;
        kick(1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        vectors += 1;
        if (bus.busy !== 1'b1)   begin miscompares++; $display("FAIL abort_busy_before got %b want 1", bus.busy); end
        #1;
        rst_n = 1'b0;
        #1;
        vectors += 6;
        if (bus.busy !== 1'b0)     begin miscompares++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        if (bus.comp_clk !== 1'b0) begin miscompares++; $display("FAIL abort_comp_clk got %b want 0", bus.comp_clk); end
        if (bus.samp !== 1'b0)     begin miscompares++; $display("FAIL abort_samp got %b want 0", bus.samp); end
        if (bus.dac_n !== 8'hFF)   begin miscompares++; $display("FAIL abort_dac_n got %h want ff", bus.dac_n); end
        if (bus.data !== 8'h00)    begin miscompares++; $display("FAIL abort_data got %h want 00", bus.data); end
        if (bus.valid !== 1'b0)    begin miscompares++; $display("FAIL abort_valid got %b want 0", bus.valid); end
        repeat (3) begin
            @(negedge clk);
            if (bus.valid === 1'b1) nvalid++;
        end
        vectors += 1;
        if (nvalid != 0)         begin miscompares++; $display("FAIL abort_no_strobe got %0d want 0", nvalid); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        vectors += 1;
        if (bus.samp !== 1'b1)   begin miscompares++; $display("FAIL abort_first_start got %b want 1", bus.samp); end
        run_conv(lat, ns, nc, d2, dp);
        vectors += 2;
        if (lat != 18)           begin miscompares++; $display("FAIL abort_relat got %0d want 18", lat); end
        if (bus.data !== 8'h5A)  begin miscompares++; $display("FAIL abort_redata got %h want 5a", bus.data); end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_basic();
        test_err();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sar_ctrl

`default_nettype wire

// File: doc/sar_ctrl.md
SAR_CTRL -- requirements
Module: sar_ctrl

Interface
REQ-001 Parameter NBITS, default 8, conversion resolution in bits (range 2..16).
REQ-002 Parameter SAMP_CYC, default 2, sampling phase length in clk cycles (range 1..15).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  conversion request; sampled on rising clk edge.
REQ-006 comp_p  input  1  comparator positive decision output.
REQ-007 comp_n  input  1  comparator negative decision output.
REQ-008 samp  output  1  sampling switch enable; high during SAMPLE.
REQ-009 comp_clk  output  1  comparator clock; high only during COMP.
REQ-010 dac_p  output  NBITS  positive DAC bit controls, equal to trial code register.
REQ-011 dac_n  output  NBITS  negative DAC bit controls, always bitwise inverse of dac_p.
REQ-012 data  output  NBITS  last completed conversion result; held until next DONE.
REQ-013 valid  output  1  one-cycle strobe, high only in DONE.
REQ-014 busy  output  1  high in SAMPLE, COMP, SETTLE; low in IDLE, DONE.
REQ-015 err  output  1  sticky flag, comparator non-decision during current/last conversion.

Function
REQ-016 FSM states IDLE, SAMPLE, COMP, SETTLE, DONE; all outputs registered (no combinational path from inputs to outputs).
REQ-017 IDLE: start=1 -> SAMPLE, trial code cleared to 0, bit index set to NBITS-1, err cleared; else remain IDLE.
REQ-018 SAMPLE lasts exactly SAMP_CYC cycles with samp=1; exit to COMP with trial code = 1 << (NBITS-1).
REQ-019 COMP lasts 1 cycle, comp_clk=1; on the edge leaving COMP, comp_p/comp_n are captured as decision for current bit index.
REQ-020 Decision: comp_p=1,comp_n=0 -> keep current bit; comp_p=0,comp_n=1 -> clear current bit; comp_p==comp_n -> clear current bit and set err.
REQ-021 SETTLE lasts 1 cycle, comp_clk=0; trial code shows the decided bit and, if index>0, next lower bit set to 1; index decrements.
REQ-022 SETTLE with index 0 (LSB decided) -> DONE; otherwise -> COMP.
REQ-023 DONE lasts 1 cycle: data <= final code, valid=1; next state SAMPLE if start=1 (back-to-back), else IDLE.
REQ-024 Latency: start accepted at edge E -> valid high in cycle starting at E + SAMP_CYC + 2*NBITS; 8-bit default = 18 cycles.
REQ-025 start while busy=1 ignored, no queuing.
REQ-026 err remains set through DONE and IDLE; cleared only when next start accepted.
REQ-027 data not modified except in DONE; partial codes never appear on data.

Reset
REQ-028 rst_n=0 asynchronously forces IDLE, samp=0, comp_clk=0, dac_p=0, dac_n=all ones, data=0, valid=0, busy=0, err=0, index=NBITS-1, sample counter 0.
REQ-029 Reset asserted mid-conversion aborts immediately; no valid strobe; data returns to 0.
REQ-030 After deassertion, first start honoured on first rising edge with rst_n=1.

Structure
REQ-031 Package sar_pkg holds state enum type (sar_state_t) and default NBITS/SAMP_CYC constants.
REQ-032 Single flat module; sample counter, bit index, code register inline; no sub-module warranted.

Verification (NBITS=8, SAMP_CYC=2)
REQ-033 Comparator model vin=0xA5 vs DAC code, start pulse -> samp high 2 cycles, 8 comp_clk pulses, valid at +18, data=0xA5, err=0.
REQ-034 comp_p=comp_n=1 forced on bit 3 decision only, target 0xFF -> data=0xF7, err=1 held until next start.
REQ-035 start held high continuously, inputs 0x00 then 0xFF -> DONE->SAMPLE back-to-back, valid every 18 cycles, data 0x00 then 0xFF.
REQ-036 start pulsed at cycle 5 of conversion -> ignored, exactly one valid strobe.
REQ-037 rst_n low at cycle 10 of conversion -> outputs at reset values within same cycle, no valid, dac_n=0xFF.
REQ-038 Every cycle assertion: dac_n == ~dac_p; comp_clk and samp never both high; busy low only in IDLE/DONE.
